conv_layer_sequencer: RTL and testbench

Control FSM that runs one stride-1, no-padding ("valid") convolution pass over a conv layer's activation and weight memories. It sits between the layer's memories and its MAC datapath. For each output element it:
- generates read indices into both memories;
- issues clear/accumulate strobes to the MAC unit, aligned to the memories' read latency;
- presents the finished element's coordinates under a valid/ready handshake.

It holds no data itself. Data flows memory → MAC, and only control flows through this block.

---
 rtl/conv_layer_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// -----------------------------------------------------------------------------
// conv_layer_sequencer
//
// Control sequencer for one stride-1, no-padding convolution pass. For every
// output element (oc, oy, ox) it clears the MAC accumulator, walks the kernel
// window over all input channels while issuing memory read indices, lets the
// final read drain into the MAC, and then presents the element's coordinates
// under a valid/ready handshake. No data passes through this block.
//
// Ports
//   clk                  clock
//   rst_n                synchronous active-low reset
//   start                begin a pass (only looked at while idle)
//   busy                 pass in progress (CLEAR/FETCH/DRAIN/EMIT)
//   done                 one-cycle pulse closing a pass
//   rd_en                memory read strobe (data returns one cycle later)
//   act_entry/act_y/act_x  activation read index
//   wt_in/wt_out/wt_ky/wt_kx  weight read index
//   mac_clear            zero the accumulator
//   mac_en               accumulate the returning read data
//   out_valid            accumulator holds a finished element
//   out_ready            consumer accepts the presented element
//   out_ch/out_y/out_x   coordinates of the presented element
// -----------------------------------------------------------------------------
module conv_layer_sequencer #(
    parameter int NUM_INPUTS  = 1,
    parameter int NUM_OUTPUTS = 1,
    parameter int INPUT_DIM   = 5,
    parameter int KERNEL_DIM  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [15:0] act_entry,
    output logic [15:0] act_y,
    output logic [15:0] act_x,
    output logic [15:0] wt_in,
    output logic [15:0] wt_out,
    output logic [15:0] wt_ky,
    output logic [15:0] wt_kx,
    output logic        mac_clear,
    output logic        mac_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_ch,
    output logic [15:0] out_y,
    output logic [15:0] out_x
);

    localparam int OUT_DIM      = INPUT_DIM - KERNEL_DIM + 1;
    // Keeps the bounds below well-formed even for an illegal configuration,
    // which is rejected at elaboration anyway.
    localparam int OUT_DIM_SAFE = (OUT_DIM > 0) ? OUT_DIM : 1;

    localparam logic [15:0] LAST_IC  = 16'(NUM_INPUTS - 1);
    localparam logic [15:0] LAST_K   = 16'(KERNEL_DIM - 1);
    localparam logic [15:0] LAST_OC  = 16'(NUM_OUTPUTS - 1);
    localparam logic [15:0] LAST_POS = 16'(OUT_DIM_SAFE - 1);

    generate
        if (KERNEL_DIM > INPUT_DIM) begin : g_bad_kernel
            initial begin
                $display("conv_layer_sequencer: KERNEL_DIM (%0d) larger than INPUT_DIM (%0d)",
                         KERNEL_DIM, INPUT_DIM);
                $finish;
            end
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_EMIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] oc_q, oc_d;
    logic [15:0] oy_q, oy_d;
    logic [15:0] ox_q, ox_d;
    logic [15:0] ic_q, ic_d;
    logic [15:0] ky_q, ky_d;
    logic [15:0] kx_q, kx_d;
    logic        mac_en_q;

    // State and loop-counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            oc_q    <= 16'd0;
            oy_q    <= 16'd0;
            ox_q    <= 16'd0;
            ic_q    <= 16'd0;
            ky_q    <= 16'd0;
            kx_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            oc_q    <= oc_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            ic_q    <= ic_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
        end
    end

    // Read strobe delayed by the memory latency becomes the accumulate strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mac_en_q <= 1'b0;
        end else begin
            mac_en_q <= rd_en;
        end
    end

    // Next-state and counter advance
    always_comb begin
        state_d = state_q;
        oc_d    = oc_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        ic_d    = ic_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    oc_d    = 16'd0;
                    oy_d    = 16'd0;
                    ox_d    = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ic_d    = 16'd0;
                ky_d    = 16'd0;
                kx_d    = 16'd0;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // kx fastest, then ky, then input channel
                if (kx_q != LAST_K) begin
                    kx_d = kx_q + 16'd1;
                end else begin
                    kx_d = 16'd0;
                    if (ky_q != LAST_K) begin
                        ky_d = ky_q + 16'd1;
                    end else begin
                        ky_d = 16'd0;
                        if (ic_q != LAST_IC) begin
                            ic_d = ic_q + 16'd1;
                        end else begin
                            ic_d    = 16'd0;
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                // Position only moves once the consumer has taken the element
                if (out_ready) begin
                    state_d = ST_CLEAR;
                    if (ox_q != LAST_POS) begin
                        ox_d = ox_q + 16'd1;
                    end else begin
                        ox_d = 16'd0;
                        if (oy_q != LAST_POS) begin
                            oy_d = oy_q + 16'd1;
                        end else begin
                            oy_d = 16'd0;
                            if (oc_q != LAST_OC) begin
                                oc_d = oc_q + 16'd1;
                            end else begin
                                oc_d    = 16'd0;
                                state_d = ST_DONE;
                            end
                        end
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode; indices and coordinates are forced to zero outside
    // the states that own them
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        mac_clear = 1'b0;
        out_valid = 1'b0;
        act_entry = 16'd0;
        act_y     = 16'd0;
        act_x     = 16'd0;
        wt_in     = 16'd0;
        wt_out    = 16'd0;
        wt_ky     = 16'd0;
        wt_kx     = 16'd0;
        out_ch    = 16'd0;
        out_y     = 16'd0;
        out_x     = 16'd0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_CLEAR: begin
                busy      = 1'b1;
                mac_clear = 1'b1;
            end
            ST_FETCH: begin
                busy      = 1'b1;
                rd_en     = 1'b1;
                act_entry = ic_q;
                act_y     = oy_q + ky_q;
                act_x     = ox_q + kx_q;
                wt_in     = ic_q;
                wt_out    = oc_q;
                wt_ky     = ky_q;
                wt_kx     = kx_q;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_ch    = oc_q;
                out_y     = oy_q;
                out_x     = ox_q;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign mac_en = mac_en_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_sequencer
//
// Two sequencer instances: index 0 uses the default geometry (1,1,5,3),
// index 1 uses (2,2,4,3). Expected element coordinates are queued when a pass
// is started; each CLEAR expands the head element into its expected read
// trace. A negedge monitor compares reads, mac_en lag, handshake hold and
// transfers against those queues; the directed sequence checks timing.
// -----------------------------------------------------------------------------
module tb_conv_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_s     [2];
    logic        start_s     [2];
    logic        out_ready_s [2];
    logic        busy_s      [2];
    logic        done_s      [2];
    logic        rd_en_s     [2];
    logic        mac_clear_s [2];
    logic        mac_en_s    [2];
    logic        out_valid_s [2];
    logic [15:0] act_entry_s [2];
    logic [15:0] act_y_s     [2];
    logic [15:0] act_x_s     [2];
    logic [15:0] wt_in_s     [2];
    logic [15:0] wt_out_s    [2];
    logic [15:0] wt_ky_s     [2];
    logic [15:0] wt_kx_s     [2];
    logic [15:0] out_ch_s    [2];
    logic [15:0] out_y_s     [2];
    logic [15:0] out_x_s     [2];

    int p_ni [2] = '{1, 2};
    int p_no [2] = '{1, 2};
    int p_id [2] = '{5, 4};
    int p_kd [2] = '{3, 3};

    int checks = 0;
    int errors = 0;

    logic [47:0]  cq [2][$];
    logic [111:0] rq [2][$];
    logic         exp_mac  [2] = '{1'b0, 1'b0};
    logic         pv_valid [2] = '{1'b0, 1'b0};
    logic         pv_ready [2] = '{1'b0, 1'b0};
    logic         pv_rst   [2] = '{1'b0, 1'b0};
    logic [47:0]  pv_coord [2] = '{48'd0, 48'd0};
    int           xfer     [2] = '{0, 0};
    logic [47:0]  mc;
    logic [111:0] mr;

    conv_layer_sequencer #(
        .NUM_INPUTS(1), .NUM_OUTPUTS(1), .INPUT_DIM(5), .KERNEL_DIM(3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n_s[0]), .start(start_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .rd_en(rd_en_s[0]),
        .act_entry(act_entry_s[0]), .act_y(act_y_s[0]), .act_x(act_x_s[0]),
        .wt_in(wt_in_s[0]), .wt_out(wt_out_s[0]), .wt_ky(wt_ky_s[0]), .wt_kx(wt_kx_s[0]),
        .mac_clear(mac_clear_s[0]), .mac_en(mac_en_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .out_ch(out_ch_s[0]), .out_y(out_y_s[0]), .out_x(out_x_s[0])
    );

    conv_layer_sequencer #(
        .NUM_INPUTS(2), .NUM_OUTPUTS(2), .INPUT_DIM(4), .KERNEL_DIM(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_s[1]), .start(start_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .rd_en(rd_en_s[1]),
        .act_entry(act_entry_s[1]), .act_y(act_y_s[1]), .act_x(act_x_s[1]),
        .wt_in(wt_in_s[1]), .wt_out(wt_out_s[1]), .wt_ky(wt_ky_s[1]), .wt_kx(wt_kx_s[1]),
        .mac_clear(mac_clear_s[1]), .mac_en(mac_en_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .out_ch(out_ch_s[1]), .out_y(out_y_s[1]), .out_x(out_x_s[1])
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [111:0] idx_of(input int d);
        return {act_entry_s[d], act_y_s[d], act_x_s[d],
                wt_in_s[d], wt_out_s[d], wt_ky_s[d], wt_kx_s[d]};
    endfunction

    function automatic logic [47:0] crd_of(input int d);
        return {out_ch_s[d], out_y_s[d], out_x_s[d]};
    endfunction

    function automatic logic [5:0] ctl_of(input int d);
        return {busy_s[d], done_s[d], rd_en_s[d], mac_clear_s[d], mac_en_s[d], out_valid_s[d]};
    endfunction

    // Expected output order of one full pass: ox fastest, then oy, then oc
    task automatic push_pass(input int d);
        int od;
        od = p_id[d] - p_kd[d] + 1;
        for (int oc = 0; oc < p_no[d]; oc++)
            for (int oy = 0; oy < od; oy++)
                for (int ox = 0; ox < od; ox++)
                    cq[d].push_back({16'(oc), 16'(oy), 16'(ox)});
    endtask

    // Expected read trace of one element: kx fastest, then ky, then ic
    task automatic gen_reads(input int d, input logic [47:0] c);
        logic [15:0] oc, oy, ox;
        oc = c[47:32];
        oy = c[31:16];
        ox = c[15:0];
        for (int ic = 0; ic < p_ni[d]; ic++)
            for (int ky = 0; ky < p_kd[d]; ky++)
                for (int kx = 0; kx < p_kd[d]; kx++)
                    rq[d].push_back({16'(ic), oy + 16'(ky), ox + 16'(kx),
                                     16'(ic), oc, 16'(ky), 16'(kx)});
    endtask

    // Cycle monitor for both instances
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check("mac_en_lag", 128'(mac_en_s[d]), 128'(exp_mac[d]));
            if (rd_en_s[d]) begin
                check("read_expected", 128'(rq[d].size() > 0), 128'(1'b1));
                if (rq[d].size() > 0) begin
                    mr = rq[d].pop_front();
                    check("read_index", 128'(idx_of(d)), 128'(mr));
                end
            end else begin
                check("index_idle_zero", 128'(idx_of(d)), 128'(0));
            end
            if (mac_clear_s[d]) begin
                check("clear_reads_drained", 128'(rq[d].size()), 128'(0));
                check("clear_elem_expected", 128'(cq[d].size() > 0), 128'(1'b1));
                if (cq[d].size() > 0) gen_reads(d, cq[d][0]);
            end
            if (pv_valid[d] && !pv_ready[d] && pv_rst[d]) begin
                check("valid_hold", 128'({out_valid_s[d], crd_of(d)}), 128'({1'b1, pv_coord[d]}));
            end
            if (out_valid_s[d] && out_ready_s[d]) begin
                xfer[d]++;
                check("xfer_expected", 128'(cq[d].size() > 0), 128'(1'b1));
                check("xfer_reads_done", 128'(rq[d].size()), 128'(0));
                if (cq[d].size() > 0) begin
                    mc = cq[d].pop_front();
                    check("xfer_coord", 128'(crd_of(d)), 128'(mc));
                end
            end
            exp_mac[d]  = rd_en_s[d] & rst_n_s[d];
            pv_valid[d] = out_valid_s[d];
            pv_ready[d] = out_ready_s[d];
            pv_rst[d]   = rst_n_s[d];
            pv_coord[d] = crd_of(d);
        end
    end

    task automatic start_pass(input int d);
        push_pass(d);
        @(posedge clk); #2;
        start_s[d] = 1'b1;
        @(posedge clk); #2;
        start_s[d] = 1'b0;
    endtask

    // Counts cycles from the current (CLEAR) negedge up to and including done
    task automatic wait_done(input int d, input int bound, output int n, output logic pb);
        n  = 1;
        pb = busy_s[d];
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (done_s[d]) break;
            pb = busy_s[d];
        end
        check("done_seen", 128'(done_s[d]), 128'(1'b1));
    endtask

    int   n;
    int   base;
    logic pb;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n_s[d]     = 1'b0;
            start_s[d]     = 1'b0;
            out_ready_s[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ctl", 128'(ctl_of(d)), 128'(0));
            check("reset_idx", 128'(idx_of(d)), 128'(0));
            check("reset_crd", 128'(crd_of(d)), 128'(0));
        end
        @(posedge clk); #2;
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;

        // Pass 1: default geometry, no stalls
        start_pass(0);
        @(negedge clk);
        check("p1_clear", 128'({mac_clear_s[0], busy_s[0]}), 128'(2'b11));
        wait_done(0, 400, n, pb);
        check("p1_cycles", 128'(n), 128'(109));
        check("p1_busy_before_done", 128'(pb), 128'(1'b1));
        check("p1_busy_at_done", 128'(busy_s[0]), 128'(1'b0));
        check("p1_xfers", 128'(xfer[0]), 128'(9));

        // start during DONE is ignored, held one more cycle it starts a pass
        start_s[0] = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        check("start_at_done_ignored", 128'({busy_s[0], mac_clear_s[0]}), 128'(0));
        push_pass(0);
        @(posedge clk); #2;
        start_s[0] = 1'b0;
        @(negedge clk);
        check("p2_clear", 128'({mac_clear_s[0], busy_s[0]}), 128'(2'b11));

        // Pass 2: start pulse while busy, then backpressure on first element
        @(posedge clk); #2;
        start_s[0]     = 1'b1;
        out_ready_s[0] = 1'b0;
        @(posedge clk); #2;
        start_s[0] = 1'b0;
        n = 0;
        while (!out_valid_s[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("p2_valid_seen", 128'(out_valid_s[0]), 128'(1'b1));
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 128'(out_valid_s[0]), 128'(1'b1));
            check("stall_coord", 128'(crd_of(0)), 128'(0));
            check("stall_quiet", 128'({rd_en_s[0], mac_clear_s[0], mac_en_s[0]}), 128'(0));
            @(negedge clk);
        end
        @(posedge clk); #2;
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        check("release_valid", 128'(out_valid_s[0]), 128'(1'b1));
        @(negedge clk);
        check("release_next_clear", 128'(mac_clear_s[0]), 128'(1'b1));
        wait_done(0, 400, n, pb);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_done_idle", 128'({busy_s[0], done_s[0], mac_clear_s[0], rd_en_s[0]}), 128'(0));
        end
        check("p2_xfers", 128'(xfer[0]), 128'(18));
        check("p2_queue_empty", 128'(cq[0].size()), 128'(0));

        // Reset in the middle of FETCH, then a clean pass
        start_pass(0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_fetch", 128'(rd_en_s[0]), 128'(1'b1));
        @(posedge clk); #2;
        rst_n_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ctl", 128'(ctl_of(0)), 128'(0));
        check("rst_idx", 128'(idx_of(0)), 128'(0));
        check("rst_crd", 128'(crd_of(0)), 128'(0));
        @(posedge clk); #2;
        rst_n_s[0] = 1'b1;
        cq[0].delete();
        rq[0].delete();
        base = xfer[0];
        start_pass(0);
        @(negedge clk);
        check("p3_clear", 128'(mac_clear_s[0]), 128'(1'b1));
        wait_done(0, 400, n, pb);
        check("p3_cycles", 128'(n), 128'(109));
        check("p3_xfers", 128'(xfer[0] - base), 128'(9));

        // Multi-channel geometry (2,2,4,3)
        start_pass(1);
        @(negedge clk);
        check("b_clear", 128'(mac_clear_s[1]), 128'(1'b1));
        wait_done(1, 1000, n, pb);
        check("b_cycles", 128'(n), 128'(169));
        check("b_xfers", 128'(xfer[1]), 128'(8));
        check("b_queue_empty", 128'(cq[1].size()), 128'(0));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
